audio_adc_rx: RTL and testbench

Serial audio receiver for the codec's ADC path. It runs on CLOCK_27 and samples the codec bit clock, ADC LR clock and ADC data pins, all treated as asynchronous inputs. It deserializes left-justified, MSB-first words into parallel left/right samples and flags malformed frames. It is the capture-side counterpart of the DAC serializer in the piano top level and reuses the same AUD_BCLK / AUD_ADCLRCK timebase.

---
 rtl/audio_adc_rx.sv | 181 ++++++++++++++++++
 tb/tb_audio_adc_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx.sv
// Codec ADC-path receiver: synchronizes BCLK/LRCK/DAT into CLOCK_27 and deserializes
// left-justified MSB-first words into a left/right sample pair.
//   state     | meaning
//   IDLE      | after reset, waiting for the first LRCK edge
//   SHIFT     | capturing bits of the current channel word
//   WORD_DONE | one cycle in which the finished word is presented
//   WAIT      | ignoring padding bits until the next LRCK edge
module audio_adc_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLOCK_27,
    input  logic                  Reset,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid,
    output logic                  short_frame,
    output logic                  rx_active
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SHIFT     = 2'd1,
        S_WORD_DONE = 2'd2,
        S_WAIT      = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrck_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_bclk_hist;
    logic                   r_lrck_hist;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_start;
    logic                   w_shift;
    logic                   w_short;
    logic                   w_commit;

    // Only DATA_WIDTH-1 bits are ever stored: the last bit goes straight into the commit.
    logic [DATA_WIDTH-2:0]  r_shift;
    logic [DATA_WIDTH-1:0]  w_shift_next;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_chan;
    logic [DATA_WIDTH-1:0]  r_left_hold;
    logic [DATA_WIDTH-1:0]  r_left_sample;
    logic [DATA_WIDTH-1:0]  r_right_sample;
    logic                   r_sample_valid;
    logic                   r_short_frame;
    logic                   r_rx_active;

    logic                   w_bclk;
    logic                   w_lrck;
    logic                   w_dat;
    logic                   w_bclk_rise;
    logic                   w_lr_edge;

    always_ff @(posedge CLOCK_27 or posedge Reset) begin
        if (Reset) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
            r_bclk_hist <= 1'b0;
            r_lrck_hist <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
            r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
            r_bclk_hist <= r_bclk_sync[SYNC_STAGES-1];
            r_lrck_hist <= r_lrck_sync[SYNC_STAGES-1];
        end
    end

    assign w_bclk       = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrck       = r_lrck_sync[SYNC_STAGES-1];
    assign w_dat        = r_dat_sync[SYNC_STAGES-1];
    assign w_bclk_rise  = w_bclk & ~r_bclk_hist;
    assign w_lr_edge    = w_lrck ^ r_lrck_hist;
    assign w_shift_next = {r_shift, w_dat};

    always_ff @(posedge CLOCK_27 or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_short      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE, S_WAIT: begin
                if (w_lr_edge) begin
                    w_start      = 1'b1;
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_lr_edge) begin
                    // LRCK edge beats a coincident BCLK rise; that rise becomes the new MSB.
                    w_start = 1'b1;
                    w_short = 1'b1;
                end else if (w_bclk_rise) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        w_commit     = 1'b1;
                        w_next_state = S_WORD_DONE;
                    end
                end
            end
            S_WORD_DONE: begin
                w_next_state = S_WAIT;
                if (w_lr_edge) begin
                    w_start      = 1'b1;
                    w_next_state = S_SHIFT;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_27 or posedge Reset) begin
        if (Reset) begin
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_chan         <= 1'b0;
            r_left_hold    <= '0;
            r_left_sample  <= '0;
            r_right_sample <= '0;
            r_sample_valid <= 1'b0;
            r_short_frame  <= 1'b0;
            r_rx_active    <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_rx_active    <= (r_state == S_SHIFT);

            if (w_start) begin
                r_chan <= w_lrck;
                if (w_bclk_rise) begin
                    r_shift   <= (DATA_WIDTH-1)'(w_dat);
                    r_bit_cnt <= CNT_W'(1);
                end else begin
                    r_shift   <= '0;
                    r_bit_cnt <= '0;
                end
            end else if (w_shift) begin
                r_shift   <= w_shift_next[DATA_WIDTH-2:0];
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end

            // Words are committed on entry to WORD_DONE so the pulse is visible during it.
            if (w_commit) begin
                if (r_chan) begin
                    r_left_hold <= w_shift_next;
                end else begin
                    r_right_sample <= w_shift_next;
                    r_left_sample  <= r_left_hold;
                    r_sample_valid <= 1'b1;
                end
            end

            if (w_short)        r_short_frame <= 1'b1;
            else if (clear_err) r_short_frame <= 1'b0;
        end
    end

    assign left_sample  = r_left_sample;
    assign right_sample = r_right_sample;
    assign sample_valid = r_sample_valid;
    assign short_frame  = r_short_frame;
    assign rx_active    = r_rx_active;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: drives codec-style frames (directed and random) and checks
// every presented left/right pair against a word-level model of the expected pairs.
module tb_audio_adc_rx;

    logic        CLOCK_27    = 1'b0;
    logic        Reset       = 1'b1;
    logic        AUD_BCLK    = 1'b0;
    logic        AUD_ADCLRCK = 1'b0;
    logic        AUD_ADCDAT  = 1'b0;
    logic        clear_err   = 1'b0;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic        short_frame;
    logic        rx_active;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_left_hold = '0;
    logic [31:0] exp_q[$];
    bit          exp_short = 1'b0;
    logic        prev_valid = 1'b0;

    audio_adc_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .CLOCK_27    (CLOCK_27),
        .Reset       (Reset),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_ADCLRCK (AUD_ADCLRCK),
        .AUD_ADCDAT  (AUD_ADCDAT),
        .clear_err   (clear_err),
        .left_sample (left_sample),
        .right_sample(right_sample),
        .sample_valid(sample_valid),
        .short_frame (short_frame),
        .rx_active   (rx_active)
    );

    always #5 CLOCK_27 = ~CLOCK_27;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge CLOCK_27);
    endtask

    // One channel word: nbits data bits MSB first, then npad random padding bits.
    // aligned: LRCK and MSB change together with the first rising BCLK edge.
    // track: update the model (full left -> hold, full right -> expected pair, short -> flag).
    task automatic send_word(input logic lr, input logic [15:0] w, input int nbits,
                             input int npad, input int half, input bit aligned, input bit track);
        if (track) begin
            if (nbits == 16) begin
                if (lr) m_left_hold = w;
                else    exp_q.push_back({m_left_hold, w});
            end else begin
                exp_short = 1'b1;
            end
        end
        for (int i = 0; i < nbits + npad; i++) begin
            logic d;
            d = (i < nbits) ? w[15-i] : 1'($urandom_range(0, 1));
            AUD_BCLK = 1'b0;
            if (!(aligned && i == 0)) begin
                AUD_ADCLRCK = lr;
                AUD_ADCDAT  = d;
            end
            clks(half);
            AUD_ADCLRCK = lr;
            AUD_ADCDAT  = d;
            AUD_BCLK    = 1'b1;
            clks(half);
        end
    endtask

    task automatic settle();
        clks(40);
        chk("pending_pairs", exp_q.size(), 0);
    endtask

    always @(negedge CLOCK_27) begin
        if (Reset) begin
            prev_valid = 1'b0;
        end else begin
            if (sample_valid) begin
                chk("valid_one_cycle", prev_valid, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", sample_valid, 0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("pair", {left_sample, right_sample}, e);
                end
            end
            prev_valid = sample_valid;
        end
    end

    initial begin
        clks(5);
        chk("reset_outputs", {left_sample, right_sample, sample_valid, short_frame, rx_active}, 0);
        Reset = 1'b0;
        clks(5);

        // clean frame
        send_word(1'b1, 16'hA5C3, 16, 16, 12, 1'b0, 1'b1);
        send_word(1'b0, 16'h3C5A, 16, 16, 12, 1'b0, 1'b1);
        settle();
        chk("clean_left", left_sample, 16'hA5C3);
        chk("clean_right", right_sample, 16'h3C5A);
        chk("clean_short", short_frame, 0);
        chk("clean_rx_idle", rx_active, 0);

        // four consecutive frames
        for (int f = 0; f < 4; f++) begin
            send_word(1'b1, 16'h1100 + 16'(f * 16'h0101), 16, 16, 12, 1'b0, 1'b1);
            send_word(1'b0, 16'h2200 + 16'(f * 16'h0011), 16, 16, 12, 1'b0, 1'b1);
        end
        settle();

        // short left word, then clean frames, then clear
        send_word(1'b1, 16'hFFFF, 10, 0, 12, 1'b0, 1'b1);
        send_word(1'b0, 16'h1234, 16, 16, 12, 1'b0, 1'b1);
        send_word(1'b1, 16'hCAFE, 16, 16, 12, 1'b0, 1'b1);
        send_word(1'b0, 16'hF00D, 16, 16, 12, 1'b0, 1'b1);
        settle();
        chk("short_set", short_frame, exp_short);
        chk("after_short_left", left_sample, 16'hCAFE);
        clear_err = 1'b1;
        clks(1);
        clear_err = 1'b0;
        exp_short = 1'b0;
        clks(2);
        chk("short_cleared", short_frame, 0);

        // LRCK edge and BCLK rise in the same cycle, MSB = 1
        send_word(1'b1, 16'h8421, 16, 16, 12, 1'b1, 1'b1);
        send_word(1'b0, 16'h7E81, 16, 16, 12, 1'b0, 1'b1);
        settle();
        chk("aligned_msb", left_sample[15], 1);

        // reset in the middle of a right word
        send_word(1'b1, 16'h5A5A, 16, 16, 12, 1'b0, 1'b1);
        send_word(1'b0, 16'h6699, 8, 0, 12, 1'b0, 1'b0);
        chk("rx_active_mid", rx_active, 1);
        Reset = 1'b1;
        #1;
        chk("reset_async", {left_sample, right_sample, sample_valid, short_frame, rx_active}, 0);
        m_left_hold = '0;
        exp_short   = 1'b0;
        clks(3);
        Reset = 1'b0;
        send_word(1'b0, 16'h9900, 8, 16, 12, 1'b0, 1'b0);
        settle();
        send_word(1'b1, 16'h0F0F, 16, 16, 12, 1'b0, 1'b1);
        send_word(1'b0, 16'hF0F0, 16, 16, 12, 1'b0, 1'b1);
        settle();
        chk("post_reset_short", short_frame, 0);

        // random words with random BCLK rate and occasional truncation
        for (int w = 0; w < 40; w++) begin
            bit          full;
            int          nbits;
            int          npad;
            logic [15:0] data;
            full  = (w == 39) || ($urandom_range(0, 3) != 0);
            nbits = full ? 16 : $urandom_range(1, 15);
            npad  = full ? $urandom_range(0, 16) : 0;
            data  = 16'($urandom);
            send_word((w % 2) == 0, data, nbits, npad, $urandom_range(3, 14), 1'b0, 1'b1);
        end
        settle();
        chk("random_short", short_frame, exp_short);

        // first word after reset is a right word: left presented as 0
        AUD_ADCLRCK = 1'b1;
        Reset       = 1'b1;
        m_left_hold = '0;
        exp_short   = 1'b0;
        clks(4);
        Reset = 1'b0;
        clks(10);
        send_word(1'b0, 16'hBEEF, 16, 16, 12, 1'b0, 1'b1);
        settle();
        chk("right_first_left", left_sample, 16'h0000);
        chk("right_first_right", right_sample, 16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
